// File: rtl/ex_mem_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_pkg
// Shared definitions for the EX/MEM pipeline register of the 5-stage MIPS
// core: bus widths, the NOP aluop, the stall-vector bit positions that this
// register looks at, and the one-hot action produced by the stall/flush
// decoder.
// ---------------------------------------------------------------------------
package ex_mem_reg_pkg;

    // Bus widths used throughout the core
    localparam int REG_ADDR_W   = 5;
    localparam int REG_W        = 32;
    localparam int ALUOP_W      = 8;
    localparam int DOUBLE_REG_W = 2 * REG_W;
    localparam int STALL_W      = 6;

    localparam logic [REG_W-1:0]   ZeroWord  = 32'h0000_0000;
    localparam logic [ALUOP_W-1:0] NOP_ALUOP = 8'h00;

    // Positions in the ctrl stall vector (bit0 PC ... bit5 WB)
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    // What the register bank does on the next rising edge; exactly one
    // action is active per cycle.
    typedef enum logic [4:0] {
        ACT_RESET   = 5'b00001,
        ACT_FLUSH   = 5'b00010,
        ACT_BUBBLE  = 5'b00100,
        ACT_HOLD    = 5'b01000,
        ACT_ADVANCE = 5'b10000
    } pipe_action_e;

endpackage

// File: rtl/ex_mem_reg_pipe_ctrl_dec.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_dec
// Turns reset, exception flush and the two relevant stall bits into the
// single one-hot action the EX/MEM register bank applies on the next edge.
//
// Ports:
//   rst       in   synchronous reset request
//   flush     in   exception flush from ctrl
//   stall_ex  in   EX stage stalled
//   stall_mem in   MEM stage stalled
//   action    out  one-hot action (reset/flush/bubble/hold/advance)
// ---------------------------------------------------------------------------
module pipe_ctrl_dec
    import ex_mem_reg_pkg::*;
(
    input  logic         rst,
    input  logic         flush,
    input  logic         stall_ex,
    input  logic         stall_mem,
    output pipe_action_e action
);

    // Fixed priority: reset, then flush (beats any stall), then stall.
    // EX stalled while MEM keeps going means MEM must get a bubble; both
    // stalled means hold. MEM stalled with EX running never comes from
    // ctrl and falls through to advance.
    always_comb begin
        action = ACT_ADVANCE;
        if (rst) begin
            action = ACT_RESET;
        end else if (flush) begin
            action = ACT_FLUSH;
        end else if (stall_ex) begin
            action = stall_mem ? ACT_HOLD : ACT_BUBBLE;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX -> MEM pipeline register. Captures EX results every cycle and presents
// them to MEM one cycle later; supports bubble/hold stalls and exception
// flush, and carries the madd/msub accumulate temp and cycle count back to
// EX while EX is stalled.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall[SW-1:0], flush     pipeline control from ctrl
//   ex_wd/ex_wreg/ex_wdata   writeback target and ALU result from EX
//   ex_whilo/ex_hi/ex_lo     HI/LO update from EX
//   ex_aluop/ex_mem_addr/ex_reg2  load/store op, address and store data
//   hilo_i, cnt_i            multi-cycle accumulate state from EX
//   mem_*                    registered copies presented to MEM
//   hilo_o, cnt_o            registered accumulate state fed back to EX
// ---------------------------------------------------------------------------
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int AW  = REG_ADDR_W,
    parameter int DW  = REG_W,
    parameter int OPW = ALUOP_W,
    parameter int SW  = STALL_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW-1:0]   stall,
    input  logic            flush,
    input  logic [AW-1:0]   ex_wd,
    input  logic            ex_wreg,
    input  logic [DW-1:0]   ex_wdata,
    input  logic            ex_whilo,
    input  logic [DW-1:0]   ex_hi,
    input  logic [DW-1:0]   ex_lo,
    input  logic [OPW-1:0]  ex_aluop,
    input  logic [DW-1:0]   ex_mem_addr,
    input  logic [DW-1:0]   ex_reg2,
    input  logic [2*DW-1:0] hilo_i,
    input  logic [1:0]      cnt_i,
    output logic [AW-1:0]   mem_wd,
    output logic            mem_wreg,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_whilo,
    output logic [DW-1:0]   mem_hi,
    output logic [DW-1:0]   mem_lo,
    output logic [OPW-1:0]  mem_aluop,
    output logic [DW-1:0]   mem_mem_addr,
    output logic [DW-1:0]   mem_reg2,
    output logic [2*DW-1:0] hilo_o,
    output logic [1:0]      cnt_o
);

    pipe_action_e action;

    logic [AW-1:0]   mem_wd_q,       mem_wd_d;
    logic            mem_wreg_q,     mem_wreg_d;
    logic [DW-1:0]   mem_wdata_q,    mem_wdata_d;
    logic            mem_whilo_q,    mem_whilo_d;
    logic [DW-1:0]   mem_hi_q,       mem_hi_d;
    logic [DW-1:0]   mem_lo_q,       mem_lo_d;
    logic [OPW-1:0]  mem_aluop_q,    mem_aluop_d;
    logic [DW-1:0]   mem_mem_addr_q, mem_mem_addr_d;
    logic [DW-1:0]   mem_reg2_q,     mem_reg2_d;
    logic [2*DW-1:0] hilo_q,         hilo_d;
    logic [1:0]      cnt_q,          cnt_d;

    // Only the EX and MEM stall bits matter to this stage.
    logic stall_unused;
    assign stall_unused = ^{stall[SW-1:STALL_MEM+1], stall[STALL_EX-1:0]};

    pipe_ctrl_dec u_dec (
        .rst       (rst),
        .flush     (flush),
        .stall_ex  (stall[STALL_EX]),
        .stall_mem (stall[STALL_MEM]),
        .action    (action)
    );

    // Next-state of the register bank as one case on the decoded action.
    // A bubble clears every MEM field (aluop becomes NOP, so no memory
    // access and no writeback). While EX is stalled the accumulate state
    // from EX is captured so EX sees it again next cycle; once EX advances
    // the multi-cycle op is finished and the temp is cleared.
    always_comb begin
        mem_wd_d       = mem_wd_q;
        mem_wreg_d     = mem_wreg_q;
        mem_wdata_d    = mem_wdata_q;
        mem_whilo_d    = mem_whilo_q;
        mem_hi_d       = mem_hi_q;
        mem_lo_d       = mem_lo_q;
        mem_aluop_d    = mem_aluop_q;
        mem_mem_addr_d = mem_mem_addr_q;
        mem_reg2_d     = mem_reg2_q;
        hilo_d         = hilo_q;
        cnt_d          = cnt_q;

        case (action)
            ACT_BUBBLE: begin
                mem_wd_d       = '0;
                mem_wreg_d     = 1'b0;
                mem_wdata_d    = '0;
                mem_whilo_d    = 1'b0;
                mem_hi_d       = '0;
                mem_lo_d       = '0;
                mem_aluop_d    = OPW'(NOP_ALUOP);
                mem_mem_addr_d = '0;
                mem_reg2_d     = '0;
                hilo_d         = hilo_i;
                cnt_d          = cnt_i;
            end
            ACT_HOLD: begin
                hilo_d = hilo_i;
                cnt_d  = cnt_i;
            end
            ACT_ADVANCE: begin
                mem_wd_d       = ex_wd;
                mem_wreg_d     = ex_wreg;
                mem_wdata_d    = ex_wdata;
                mem_whilo_d    = ex_whilo;
                mem_hi_d       = ex_hi;
                mem_lo_d       = ex_lo;
                mem_aluop_d    = ex_aluop;
                mem_mem_addr_d = ex_mem_addr;
                mem_reg2_d     = ex_reg2;
                hilo_d         = '0;
                cnt_d          = 2'b00;
            end
            default: begin
                // Reset and flush both clear everything, accumulate state included.
                mem_wd_d       = '0;
                mem_wreg_d     = 1'b0;
                mem_wdata_d    = '0;
                mem_whilo_d    = 1'b0;
                mem_hi_d       = '0;
                mem_lo_d       = '0;
                mem_aluop_d    = OPW'(NOP_ALUOP);
                mem_mem_addr_d = '0;
                mem_reg2_d     = '0;
                hilo_d         = '0;
                cnt_d          = 2'b00;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wd_q       <= '0;
            mem_wreg_q     <= 1'b0;
            mem_wdata_q    <= '0;
            mem_whilo_q    <= 1'b0;
            mem_hi_q       <= '0;
            mem_lo_q       <= '0;
            mem_aluop_q    <= '0;
            mem_mem_addr_q <= '0;
            mem_reg2_q     <= '0;
            hilo_q         <= '0;
            cnt_q          <= 2'b00;
        end else begin
            mem_wd_q       <= mem_wd_d;
            mem_wreg_q     <= mem_wreg_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_whilo_q    <= mem_whilo_d;
            mem_hi_q       <= mem_hi_d;
            mem_lo_q       <= mem_lo_d;
            mem_aluop_q    <= mem_aluop_d;
            mem_mem_addr_q <= mem_mem_addr_d;
            mem_reg2_q     <= mem_reg2_d;
            hilo_q         <= hilo_d;
            cnt_q          <= cnt_d;
        end
    end

    assign mem_wd       = mem_wd_q;
    assign mem_wreg     = mem_wreg_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_whilo    = mem_whilo_q;
    assign mem_hi       = mem_hi_q;
    assign mem_lo       = mem_lo_q;
    assign mem_aluop    = mem_aluop_q;
    assign mem_mem_addr = mem_mem_addr_q;
    assign mem_reg2     = mem_reg2_q;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
// Directed and random checks of the EX/MEM pipeline register against a
// small behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int total = 0;
    int bad   = 0;

    // The MEM-facing bundle as one record, so the model moves it as a whole.
    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
    } mem_bundle_t;

    mem_bundle_t exp_mem;
    logic [63:0] exp_hilo;
    logic [1:0]  exp_cnt;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_whilo     (ex_whilo),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .hilo_i       (hilo_i),
        .cnt_i        (cnt_i),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .hilo_o       (hilo_o),
        .cnt_o        (cnt_o)
    );

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compares every output against the model's prediction.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".wd"},    64'(mem_wd),       64'(exp_mem.wd));
        checkOutput({tag, ".wreg"},  64'(mem_wreg),     64'(exp_mem.wreg));
        checkOutput({tag, ".wdata"}, 64'(mem_wdata),    64'(exp_mem.wdata));
        checkOutput({tag, ".whilo"}, 64'(mem_whilo),    64'(exp_mem.whilo));
        checkOutput({tag, ".hi"},    64'(mem_hi),       64'(exp_mem.hi));
        checkOutput({tag, ".lo"},    64'(mem_lo),       64'(exp_mem.lo));
        checkOutput({tag, ".aluop"}, 64'(mem_aluop),    64'(exp_mem.aluop));
        checkOutput({tag, ".addr"},  64'(mem_mem_addr), 64'(exp_mem.addr));
        checkOutput({tag, ".reg2"},  64'(mem_reg2),     64'(exp_mem.reg2));
        checkOutput({tag, ".hilo"},  hilo_o,            exp_hilo);
        checkOutput({tag, ".cnt"},   64'(cnt_o),        64'(exp_cnt));
    endtask

    // Drives the control inputs; ctrl never stalls MEM while EX runs.
    task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s);
        rst   = r;
        flush = f;
        stall = s;
        assert (!(s[3] == 1'b0 && s[4] == 1'b1))
        else $error("[TB] illegal stall vector %b driven", s);
    endtask

    task automatic randomEx();
        ex_wd       = 5'($urandom);
        ex_wreg     = 1'($urandom);
        ex_wdata    = $urandom;
        ex_whilo    = 1'($urandom);
        ex_hi       = $urandom;
        ex_lo       = $urandom;
        ex_aluop    = 8'($urandom);
        ex_mem_addr = $urandom;
        ex_reg2     = $urandom;
        hilo_i      = {$urandom, $urandom};
        cnt_i       = 2'($urandom);
    endtask

    // Stage behaviour: what MEM and the EX feedback hold after the edge,
    // decided from the inputs present before it.
    task automatic tick();
        mem_bundle_t incoming;
        incoming = '{ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
                     ex_aluop, ex_mem_addr, ex_reg2};
        if (rst || flush) begin
            exp_mem  = '0;
            exp_hilo = 64'd0;
            exp_cnt  = 2'd0;
        end else if (stall[3]) begin
            if (!stall[4]) exp_mem = '0;
            exp_hilo = hilo_i;
            exp_cnt  = cnt_i;
        end else begin
            exp_mem  = incoming;
            exp_hilo = 64'd0;
            exp_cnt  = 2'd0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_mem  = '0;
        exp_hilo = 64'd0;
        exp_cnt  = 2'd0;

        // Reset with every EX input driven high
        ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_whilo = 1'b1;
        ex_hi = '1; ex_lo = '1; ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1;
        hilo_i = '1; cnt_i = '1;
        applyStimulus(1'b1, 1'b0, 6'b000000);
        @(negedge clk);
        tick();
        checkAll("reset1");
        tick();
        checkAll("reset2");

        // First capture after reset
        applyStimulus(1'b0, 1'b0, 6'b000000);
        ex_wdata = 32'h1234;
        tick();
        checkOutput("post_reset.wdata", 64'(mem_wdata), 64'h1234);

        // Advance
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF; hilo_i = 64'h5;
        tick();
        checkOutput("adv.wd",    64'(mem_wd),    64'd7);
        checkOutput("adv.wreg",  64'(mem_wreg),  64'd1);
        checkOutput("adv.wdata", 64'(mem_wdata), 64'hDEADBEEF);
        checkOutput("adv.hilo",  hilo_o,         64'h0);
        checkOutput("adv.cnt",   64'(cnt_o),     64'd0);
        checkAll("adv");

        // Bubble
        applyStimulus(1'b0, 1'b0, 6'b001111);
        hilo_i = 64'hA; cnt_i = 2'd1;
        tick();
        checkOutput("bub.wreg",  64'(mem_wreg),  64'd0);
        checkOutput("bub.wdata", 64'(mem_wdata), 64'd0);
        checkOutput("bub.aluop", 64'(mem_aluop), 64'd0);
        checkOutput("bub.hilo",  hilo_o,         64'hA);
        checkOutput("bub.cnt",   64'(cnt_o),     64'd1);
        checkAll("bub");

        // Hold
        applyStimulus(1'b0, 1'b0, 6'b000000);
        ex_wdata = 32'h55;
        tick();
        checkOutput("hold.load", 64'(mem_wdata), 64'h55);
        applyStimulus(1'b0, 1'b0, 6'b011111);
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h1000 + 32'(i);
            tick();
            checkOutput("hold.keep", 64'(mem_wdata), 64'h55);
        end
        applyStimulus(1'b0, 1'b0, 6'b000000);
        ex_wdata = 32'h77;
        tick();
        checkOutput("hold.release", 64'(mem_wdata), 64'h77);

        // Flush beats hold with nonzero state everywhere
        randomEx();
        ex_wreg = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 6'b011111);
        hilo_i = 64'hABC; cnt_i = 2'd3;
        tick();
        checkOutput("pre_flush.cnt", 64'(cnt_o), 64'd3);
        applyStimulus(1'b0, 1'b1, 6'b011111);
        tick();
        checkAll("flush");
        checkOutput("flush.wreg", 64'(mem_wreg), 64'd0);
        checkOutput("flush.hilo", hilo_o,        64'h0);

        // madd: stalled cycle carries temp, advancing cycle clears it
        applyStimulus(1'b0, 1'b0, 6'b001111);
        hilo_i = 64'h100; cnt_i = 2'd1;
        tick();
        checkOutput("madd1.hilo", hilo_o,     64'h100);
        checkOutput("madd1.cnt",  64'(cnt_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 6'b000000);
        tick();
        checkOutput("madd2.hilo", hilo_o,     64'h0);
        checkOutput("madd2.cnt",  64'(cnt_o), 64'd0);

        // Random mix of advance/bubble/hold/flush/reset
        for (int n = 0; n < 300; n++) begin
            logic [5:0] s;
            logic       r;
            logic       f;
            randomEx();
            s = 6'($urandom);
            s[3] = ($urandom_range(0, 2) != 0);
            if (!s[3]) s[4] = 1'b0;
            r = ($urandom_range(0, 24) == 0);
            f = ($urandom_range(0, 14) == 0);
            applyStimulus(r, f, s);
            tick();
            checkAll("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
